// File: rtl/board_access_arbiter_if.sv
// ---------------------------------------------------------------------------
// board_access_arbiter_if
//
// Write-request bus between the two board writers (requesters A and B) and
// board_access_arbiter.
//
//   req_a / req_b    requester -> arbiter   write request, held until granted
//   row_a / row_b    requester -> arbiter   target row index (5 bits)
//   data_a / data_b  requester -> arbiter   new row contents, bit n = column n
//   gnt_a / gnt_b    arbiter -> requester   one-cycle grant; the row write
//                                           completed on the edge that raised it
//
// Modports: master = requester side, slave = arbiter side.
// ---------------------------------------------------------------------------
interface board_access_arbiter_if #(
    parameter int COLS = 8
);
    logic            req_a;
    logic [4:0]      row_a;
    logic [COLS-1:0] data_a;
    logic            gnt_a;

    logic            req_b;
    logic [4:0]      row_b;
    logic [COLS-1:0] data_b;
    logic            gnt_b;

    modport master (
        output req_a, row_a, data_a,
        output req_b, row_b, data_b,
        input  gnt_a, gnt_b
    );

    modport slave (
        input  req_a, row_a, data_a,
        input  req_b, row_b, data_b,
        output gnt_a, gnt_b
    );
endinterface

// File: rtl/board_access_arbiter.sv
// ---------------------------------------------------------------------------
// board_access_arbiter
//
// Owns the ROWS x COLS game board. The VGA side reads single cells
// combinationally; two requesters write whole rows, but only during a write
// window of WINDOW_CYCLES clocks that opens after each frame's draw_finish.
// A frame counter emits a one-cycle frame_tick every TICK_FRAMES frames.
//
// Ports:
//   vga_clk      in   sole clock, rising edge
//   rst          in   synchronous, active-high reset
//   draw_finish  in   one pulse per frame from the VGA timing block
//   x_coord      in   [7:0]  cell column to read
//   y_coord      in   [17:0] cell row to read
//   coord_value  out  board[y_coord][x_coord], 0 when out of range
//   bus          slave modport of board_access_arbiter_if (req/row/data/gnt
//                for requesters A and B)
//   window_open  out  high while the write window is active
//   frame_tick   out  one-cycle game-tick pulse
//
// Configuration macro: ARB_ROUND_ROBIN_EN
//   defined   -> contention goes to the requester not granted most recently
//                (A wins the first contention after reset)
//   undefined -> fixed priority, A always wins contention
// ---------------------------------------------------------------------------
module board_access_arbiter #(
    parameter int ROWS          = 18,
    parameter int COLS          = 8,
    parameter int WINDOW_CYCLES = 800,
    parameter int TICK_FRAMES   = 30
) (
    input  logic                  vga_clk,
    input  logic                  rst,
    input  logic                  draw_finish,
    input  logic [7:0]            x_coord,
    input  logic [17:0]           y_coord,
    output logic                  coord_value,
    board_access_arbiter_if.slave bus,
    output logic                  window_open,
    output logic                  frame_tick
);

    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;

    typedef enum logic {
        DISPLAY = 1'b0,
        WINDOW  = 1'b1
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [15:0]     win_cnt;
    logic [15:0]     win_cnt_next;
    logic [7:0]      frame_cnt;
    logic [7:0]      frame_cnt_next;
    logic            frame_tick_next;

    logic            gnt_a;
    logic            gnt_b;
    logic            elig_a;
    logic            elig_b;
    logic            grant_a;
    logic            grant_b;
    logic            row_a_ok;
    logic            row_b_ok;

    logic [COLS-1:0] board [ROWS];

    logic             coord_in_range;
    logic [ROW_W-1:0] y_idx;
    logic [COL_W-1:0] x_idx;

`ifdef ARB_ROUND_ROBIN_EN
    // Set when B should win the next contention (A was granted last).
    logic            prefer_b;
`endif

    // -----------------------------------------------------------------------
    // Window / frame sequencing
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_next      = state;
        win_cnt_next    = win_cnt;
        frame_cnt_next  = frame_cnt;
        frame_tick_next = 1'b0;

        case (state)
            DISPLAY: begin
                if (draw_finish) begin
                    state_next   = WINDOW;
                    win_cnt_next = '0;
                    // The tick is registered alongside the state change, so it
                    // lines up with the first cycle window_open reads 1.
                    if (frame_cnt == 8'(TICK_FRAMES - 1)) begin
                        frame_cnt_next  = '0;
                        frame_tick_next = 1'b1;
                    end else begin
                        frame_cnt_next = frame_cnt + 8'd1;
                    end
                end
            end
            WINDOW: begin
                // draw_finish is deliberately ignored here.
                win_cnt_next = win_cnt + 16'd1;
                if (win_cnt == 16'(WINDOW_CYCLES - 1)) begin
                    state_next = DISPLAY;
                end
            end
            default: state_next = DISPLAY;
        endcase
    end

    // -----------------------------------------------------------------------
    // Arbitration
    // -----------------------------------------------------------------------
    // A requester holding its grant this cycle sits out one edge, which
    // forces the minimum one-cycle gap between its consecutive grants.
    assign elig_a   = bus.req_a && !gnt_a;
    assign elig_b   = bus.req_b && !gnt_b;
    assign row_a_ok = 32'(bus.row_a) < ROWS;
    assign row_b_ok = 32'(bus.row_b) < ROWS;

    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        // The final window edge still grants: state is WINDOW on that edge.
        if (state == WINDOW) begin
`ifdef ARB_ROUND_ROBIN_EN
            if (elig_a && elig_b) begin
                grant_a = !prefer_b;
                grant_b = prefer_b;
            end else begin
                grant_a = elig_a;
                grant_b = elig_b;
            end
`else
            grant_a = elig_a;
            grant_b = elig_b && !elig_a;
`endif
        end
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge vga_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            state      <= DISPLAY;
            win_cnt    <= '0;
            frame_cnt  <= '0;
            frame_tick <= 1'b0;
            gnt_a      <= 1'b0;
            gnt_b      <= 1'b0;
        end else begin
            state      <= state_next;
            win_cnt    <= win_cnt_next;
            frame_cnt  <= frame_cnt_next;
            frame_tick <= frame_tick_next;
            gnt_a      <= grant_a;
            gnt_b      <= grant_b;
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    always_ff @(posedge vga_clk) begin
        if (rst) begin
            prefer_b <= 1'b0;
        end else if (grant_a) begin
            prefer_b <= 1'b1;
        end else if (grant_b) begin
            prefer_b <= 1'b0;
        end
    end
`endif

    // Out-of-range rows are still granted; they simply do not write.
    always_ff @(posedge vga_clk) begin
        if (rst) begin
            // NOTE: the board is a flop array, not a RAM, because a reset has
            // to clear every cell in one edge; each row is reset explicitly.
            for (int r = 0; r < ROWS; r++) begin
                board[r] <= '0;
            end
        end else begin
            if (grant_a && row_a_ok) begin
                board[ROW_W'(bus.row_a)] <= bus.data_a;
            end
            if (grant_b && row_b_ok) begin
                board[ROW_W'(bus.row_b)] <= bus.data_b;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign window_open = (state == WINDOW);
    assign bus.gnt_a   = gnt_a;
    assign bus.gnt_b   = gnt_b;

    assign coord_in_range = (32'(x_coord) < COLS) && (32'(y_coord) < ROWS);
    assign y_idx          = ROW_W'(y_coord);
    assign x_idx          = COL_W'(x_coord);
    assign coord_value    = coord_in_range ? board[y_idx][x_idx] : 1'b0;

endmodule

// File: tb/tb_board_access_arbiter.sv
// ---------------------------------------------------------------------------
// tb_board_access_arbiter
//
// Self-checking bench for board_access_arbiter (default parameters). A
// behavioural model (window as "cycles remaining", frames as "frames seen",
// board as a byte array) runs in lock-step and is compared every cycle;
// directed sequences and a vector table add constant expectations for the
// timing corners. Honours ARB_ROUND_ROBIN_EN for the expected policy.
// ---------------------------------------------------------------------------
module tb_board_access_arbiter;

    localparam int ROWS          = 18;
    localparam int COLS          = 8;
    localparam int WINDOW_CYCLES = 800;
    localparam int TICK_FRAMES   = 30;
    localparam int NVEC          = 12;

`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        vga_clk;
    logic        rst;
    logic        draw_finish;
    logic [7:0]  x_coord;
    logic [17:0] y_coord;
    logic        coord_value;
    logic        window_open;
    logic        frame_tick;

    board_access_arbiter_if #(.COLS(COLS)) bus ();

    board_access_arbiter #(
        .ROWS          (ROWS),
        .COLS          (COLS),
        .WINDOW_CYCLES (WINDOW_CYCLES),
        .TICK_FRAMES   (TICK_FRAMES)
    ) dut (
        .vga_clk     (vga_clk),
        .rst         (rst),
        .draw_finish (draw_finish),
        .x_coord     (x_coord),
        .y_coord     (y_coord),
        .coord_value (coord_value),
        .bus         (bus),
        .window_open (window_open),
        .frame_tick  (frame_tick)
    );

    initial vga_clk = 1'b0;
    always #5 vga_clk = ~vga_clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    bit [7:0] m_board [ROWS];
    bit       m_open     = 1'b0;
    int       m_left     = 0;
    int       m_frames   = 0;
    bit       m_ga       = 1'b0;
    bit       m_gb       = 1'b0;
    bit       m_tick     = 1'b0;
    bit       m_prefer_a = 1'b1;

    task automatic model_step();
        bit ea, eb, wa, wb;
        wa = 1'b0;
        wb = 1'b0;
        if (rst) begin
            foreach (m_board[i]) m_board[i] = '0;
            m_open     = 1'b0;
            m_left     = 0;
            m_frames   = 0;
            m_tick     = 1'b0;
            m_prefer_a = 1'b1;
        end else begin
            m_tick = 1'b0;
            if (m_open) begin
                ea = bus.req_a && !m_ga;
                eb = bus.req_b && !m_gb;
                if (ea && eb) begin
                    wa = RR ? m_prefer_a : 1'b1;
                    wb = !wa;
                end else begin
                    wa = ea;
                    wb = eb;
                end
                if (wa) begin
                    if (int'(bus.row_a) < ROWS) m_board[bus.row_a] = bus.data_a;
                    m_prefer_a = 1'b0;
                end
                if (wb) begin
                    if (int'(bus.row_b) < ROWS) m_board[bus.row_b] = bus.data_b;
                    m_prefer_a = 1'b1;
                end
                m_left--;
                if (m_left == 0) m_open = 1'b0;
            end else if (draw_finish) begin
                m_open = 1'b1;
                m_left = WINDOW_CYCLES;
                m_frames++;
                if (m_frames == TICK_FRAMES) begin
                    m_frames = 0;
                    m_tick   = 1'b1;
                end
            end
        end
        m_ga = wa;
        m_gb = wb;
    endtask

    function automatic bit model_cell(input int x, input int y);
        if (x < COLS && y < ROWS) return m_board[y][x];
        return 1'b0;
    endfunction

    // One clock: model advances on the edge, DUT sampled 1 time unit later.
    task automatic cycle();
        @(posedge vga_clk);
        model_step();
        #1;
        check("model_gnt_a", bus.gnt_a, m_ga);
        check("model_gnt_b", bus.gnt_b, m_gb);
        check("model_window_open", window_open, m_open);
        check("model_frame_tick", frame_tick, m_tick);
        check("model_coord_value", coord_value, model_cell(int'(x_coord), int'(y_coord)));
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit        req_a;
        bit [4:0]  row_a;
        bit [7:0]  data_a;
        bit        req_b;
        bit [4:0]  row_b;
        bit [7:0]  data_b;
        bit [7:0]  x;
        bit [17:0] y;
        bit        exp_ga;
        bit        exp_gb;
        bit        exp_cv;
    } vec_t;

    vec_t vecs [NVEC];

    int open_cycles;
    int grants;
    int ticks;
    int k;

    initial begin
        // Rows applied one per edge inside a freshly reset window.
        vecs[0]  = '{1'b1, 5'd0, 8'h01, 1'b1, 5'd1,  8'h02, 8'd0, 18'd0,  1'b1, 1'b0, 1'b1};
        vecs[1]  = '{1'b1, 5'd2, 8'h04, 1'b1, 5'd1,  8'h02, 8'd1, 18'd1,  1'b0, 1'b1, 1'b1};
        vecs[2]  = '{1'b1, 5'd2, 8'h04, 1'b1, 5'd20, 8'hFF, 8'd2, 18'd2,  1'b1, 1'b0, 1'b1};
        vecs[3]  = '{1'b1, 5'd4, 8'h10, 1'b1, 5'd20, 8'hFF, 8'd0, 18'd20, 1'b0, 1'b1, 1'b0};
        vecs[4]  = '{1'b1, 5'd4, 8'h10, 1'b1, 5'd5,  8'h20, 8'd4, 18'd4,  1'b1, 1'b0, 1'b1};
        vecs[5]  = '{1'b0, 5'd0, 8'h00, 1'b1, 5'd5,  8'h20, 8'd5, 18'd5,  1'b0, 1'b1, 1'b1};
        vecs[6]  = '{1'b1, 5'd6, 8'h40, 1'b0, 5'd0,  8'h00, 8'd9, 18'd5,  1'b1, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 5'd0, 8'h00, 1'b0, 5'd0,  8'h00, 8'd5, 18'd6,  1'b0, 1'b0, 1'b0};
        // Contention after A was granted last: the policies differ here.
        vecs[8]  = '{1'b1, 5'd7, 8'h80, 1'b1, 5'd8,  8'h03, 8'd6, 18'd6,  !RR,  RR,   1'b1};
        vecs[9]  = '{1'b1, 5'd7, 8'h80, 1'b1, 5'd8,  8'h03, 8'd7, 18'd7,  RR,   !RR,  1'b1};
        vecs[10] = '{1'b1, 5'd7, 8'h80, 1'b1, 5'd8,  8'h03, 8'd0, 18'd8,  !RR,  RR,   1'b1};
        vecs[11] = '{1'b0, 5'd0, 8'h00, 1'b0, 5'd0,  8'h00, 8'd2, 18'd8,  1'b0, 1'b0, 1'b0};

        rst         = 1'b1;
        draw_finish = 1'b0;
        x_coord     = '0;
        y_coord     = '0;
        bus.req_a   = 1'b0;
        bus.row_a   = '0;
        bus.data_a  = '0;
        bus.req_b   = 1'b0;
        bus.row_b   = '0;
        bus.data_b  = '0;

        // ---- reset state ----
        cycle();
        cycle();
        check("rst_gnt_a", bus.gnt_a, 0);
        check("rst_gnt_b", bus.gnt_b, 0);
        check("rst_window_open", window_open, 0);
        check("rst_frame_tick", frame_tick, 0);
        check("rst_coord_value", coord_value, 0);
        rst = 1'b0;

        // ---- request held in DISPLAY, then one full window ----
        bus.req_a  = 1'b1;
        bus.row_a  = 5'd3;
        bus.data_a = 8'hA5;
        repeat (5) begin
            cycle();
            check("display_no_gnt_a", bus.gnt_a, 0);
        end
        draw_finish = 1'b1;
        cycle();
        draw_finish = 1'b0;
        check("window_rise", window_open, 1);
        check("no_gnt_on_open_edge", bus.gnt_a, 0);
        cycle();
        check("first_gnt_a", bus.gnt_a, 1);
        bus.req_a   = 1'b0;
        open_cycles = 2;
        grants      = 1;
        for (int i = 0; i < 2 * WINDOW_CYCLES && window_open; i++) begin
            cycle();
            if (window_open) open_cycles++;
            if (bus.gnt_a || bus.gnt_b) grants++;
        end
        repeat (20) begin
            cycle();
            if (bus.gnt_a || bus.gnt_b) grants++;
        end
        check("window_length", open_cycles, WINDOW_CYCLES);
        check("window_closed", window_open, 0);
        check("grant_count", grants, 1);
        x_coord = 8'd0;
        y_coord = 18'd3;
        #1 check("cell_0_3", coord_value, 1);
        x_coord = 8'd1;
        #1 check("cell_1_3", coord_value, 0);

        // ---- table-driven window ----
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        draw_finish = 1'b1;
        cycle();
        draw_finish = 1'b0;
        check("table_window_open", window_open, 1);
        for (int i = 0; i < NVEC; i++) begin
            bus.req_a  = vecs[i].req_a;
            bus.row_a  = vecs[i].row_a;
            bus.data_a = vecs[i].data_a;
            bus.req_b  = vecs[i].req_b;
            bus.row_b  = vecs[i].row_b;
            bus.data_b = vecs[i].data_b;
            x_coord    = vecs[i].x;
            y_coord    = vecs[i].y;
            cycle();
            check($sformatf("vec%0d_gnt_a", i), bus.gnt_a, vecs[i].exp_ga);
            check($sformatf("vec%0d_gnt_b", i), bus.gnt_b, vecs[i].exp_gb);
            check($sformatf("vec%0d_coord", i), coord_value, vecs[i].exp_cv);
        end

        // ---- request arriving for the last window edge ----
        for (int e = NVEC; e < WINDOW_CYCLES - 1; e++) cycle();
        check("last_cycle_still_open", window_open, 1);
        bus.req_a  = 1'b1;
        bus.row_a  = 5'd9;
        bus.data_a = 8'h55;
        cycle();
        check("last_edge_closes", window_open, 0);
        check("last_edge_gnt_a", bus.gnt_a, 1);
        repeat (3) begin
            cycle();
            check("no_gnt_after_window", bus.gnt_a, 0);
        end
        bus.req_a = 1'b0;
        x_coord   = 8'd0;
        y_coord   = 18'd9;
        #1 check("cell_0_9", coord_value, 1);

        // ---- frame tick over 31 frames, one stray mid-window pulse ----
        rst = 1'b1;
        cycle();
        rst   = 1'b0;
        ticks = 0;
        for (int p = 1; p <= TICK_FRAMES + 1; p++) begin
            draw_finish = 1'b1;
            cycle();
            draw_finish = 1'b0;
            check($sformatf("tick_frame%0d", p), frame_tick, (p == TICK_FRAMES));
            if (frame_tick) ticks++;
            for (int c = 1; c < 2 * WINDOW_CYCLES && window_open; c++) begin
                draw_finish = (p == 10 && c == 100);
                cycle();
                draw_finish = 1'b0;
                if (frame_tick) ticks++;
            end
        end
        check("tick_count", ticks, 1);

        // ---- reset in the middle of a window ----
        draw_finish = 1'b1;
        cycle();
        draw_finish = 1'b0;
        bus.req_a  = 1'b1;
        bus.row_a  = 5'd3;
        bus.data_a = 8'hFF;
        cycle();
        bus.req_a = 1'b0;
        x_coord   = 8'd0;
        y_coord   = 18'd3;
        k = 1;
        while (k < WINDOW_CYCLES / 2 - 1) begin
            cycle();
            k++;
        end
        check("pre_reset_cell", coord_value, 1);
        rst        = 1'b1;
        bus.req_a  = 1'b1;
        bus.row_a  = 5'd4;
        bus.data_a = 8'hFF;
        cycle();
        check("reset_edge_no_gnt", bus.gnt_a, 0);
        check("reset_edge_closed", window_open, 0);
        rst = 1'b0;
        repeat (3) begin
            cycle();
            check("post_reset_no_gnt", bus.gnt_a, 0);
        end
        bus.req_a = 1'b0;
        for (int y = 0; y < ROWS; y++) begin
            for (int x = 0; x < COLS; x++) begin
                x_coord = 8'(x);
                y_coord = 18'(y);
                cycle();
                check("cleared_cell", coord_value, 0);
            end
        end

        // ---- randomized traffic against the model ----
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        for (int i = 0; i < 6000; i++) begin
            if (bus.gnt_a || !bus.req_a) begin
                bus.req_a  = ($urandom_range(0, 1) == 0);
                bus.row_a  = 5'($urandom_range(0, 23));
                bus.data_a = 8'($urandom);
            end
            if (bus.gnt_b || !bus.req_b) begin
                bus.req_b  = ($urandom_range(0, 1) == 0);
                bus.row_b  = 5'($urandom_range(0, 23));
                bus.data_b = 8'($urandom);
            end
            draw_finish = ($urandom_range(0, 39) == 0);
            rst         = ($urandom_range(0, 2999) == 0);
            x_coord     = 8'($urandom_range(0, 9));
            y_coord     = 18'($urandom_range(0, 21));
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/board_access_arbiter.md
BOARD_ACCESS_ARBITER -- requirements
Module: board_access_arbiter

Interface
REQ-001 Parameter ROWS, default 18, number of board rows.
REQ-002 Parameter COLS, default 8, board cells per row.
REQ-003 Parameter WINDOW_CYCLES, default 800, length of the per-frame write window in clocks (range 1..65535).
REQ-004 Parameter TICK_FRAMES, default 30, frames per game tick (range 1..255).
REQ-005 vga_clk  in  1  sole clock; all logic on its rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 draw_finish  in  1  one-cycle pulse, once per frame, from the VGA timing block.
REQ-008 x_coord  in  8  cell column requested by the VGA timing block.
REQ-009 y_coord  in  18  cell row requested by the VGA timing block.
REQ-010 coord_value  out  1  board cell at (x_coord, y_coord); 1 = filled.
REQ-011 req_a / req_b  in  1  write request, requester A / B.
REQ-012 row_a / row_b  in  5  target row index.
REQ-013 data_a / data_b  in  COLS  new row contents; bit n = column n.
REQ-014 gnt_a / gnt_b  out  1  one-cycle grant; the row write completed on the edge that raised it.
REQ-015 window_open  out  1  high while the write window is active.
REQ-016 frame_tick  out  1  one-cycle game-tick pulse.

Function
REQ-017 Board storage: ROWS x COLS register array owned by this block; the only writers are requesters A and B.
REQ-018 coord_value: combinational board[y_coord][x_coord]; forced to 0 when x_coord >= COLS or y_coord >= ROWS.
REQ-019 FSM states: DISPLAY and WINDOW; reset state DISPLAY.
REQ-020 DISPLAY -> WINDOW on the edge sampling draw_finish = 1; window counter loads 0.
REQ-021 In WINDOW, the counter increments every cycle; WINDOW -> DISPLAY on the edge where counter = WINDOW_CYCLES-1, so WINDOW lasts exactly WINDOW_CYCLES cycles.
REQ-022 draw_finish sampled while in WINDOW: ignored; it neither restarts nor extends the window.
REQ-023 window_open: registered, equals (state == WINDOW).
REQ-024 Grant rule: on an edge where state == WINDOW, at most one eligible request is granted. The granted write is board[row] <= data, and the matching gnt is driven high for the following cycle only.
REQ-025 A requester whose gnt is currently high is ineligible on that edge. Minimum one-cycle gap between consecutive grants to the same requester.
REQ-026 Requests in DISPLAY: not granted, no write; requesters hold req until granted.
REQ-027 Row index >= ROWS: request is granted; the board is unchanged.
REQ-028 Simultaneous eligible requests: resolved per REQ-036; the loser stays pending, board unchanged for it.
REQ-029 Frame counter (8 bits): increments on each draw_finish accepted in DISPLAY.
REQ-030 At the increment from TICK_FRAMES-1 the frame counter wraps to 0, and frame_tick pulses in the same cycle window_open first reads 1.
REQ-031 A request that is pending on the final WINDOW cycle edge is granted on that edge; no grants occur after it.

Reset
REQ-032 rst = 1 on an edge: state DISPLAY, window counter 0, frame counter 0, entire board cleared to 0, round-robin pointer favouring A.
REQ-033 Outputs after reset: gnt_a = gnt_b = window_open = frame_tick = 0; coord_value = 0.
REQ-034 rst has priority over every other event, including mid-window and a simultaneous draw_finish; no write occurs on a reset edge.

Configuration
REQ-035 Macro ARB_ROUND_ROBIN_EN selects the arbitration policy.
REQ-036 ARB_ROUND_ROBIN_EN defined: on simultaneous eligible requests, grant the requester not granted most recently; the pointer updates on every grant; A wins the first contention after reset.
REQ-036a ARB_ROUND_ROBIN_EN undefined: fixed priority, A always wins contention; no pointer register.

Verification
REQ-037 Reset, then draw_finish pulse: window_open = 1 for exactly 800 cycles; zero grants outside that span.
REQ-038 req_a, row_a = 3, data_a = 8'hA5 during DISPLAY -> no gnt until window opens; gnt_a is the cycle after window_open rises. Then x_coord = 0, y_coord = 3 gives coord_value 1; x_coord = 1 gives 0.
REQ-039 req_a and req_b held continuously in WINDOW:
- with ARB_ROUND_ROBIN_EN, grants alternate A,B,A,B;
- without it, the grant sequence is A, B (during A's gap cycle), A, ...
REQ-040 30 draw_finish pulses -> exactly one frame_tick, coincident with window_open rising after pulse 30. A draw_finish mid-window is not counted.
REQ-041 row_b = 20 granted -> board unchanged. Then y_coord = 20 or x_coord = 9 gives coord_value 0.
REQ-042 rst asserted at window cycle 400 with req_a pending -> no gnt_a, window_open = 0 next cycle, all board cells read 0.
